// File: rtl/rpn_stack_engine.sv
// rtl/rpn_stack_engine.sv - RPN command engine driving a LIFO as its only master.
// Each accepted command expands into LIFO pops/pushes; results and errors are one-cycle pulses.
module rpn_stack_engine #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [data_width-1:0] cmd_operand,
  output logic                  push,
  output logic                  pop,
  output logic [data_width-1:0] w_data,
  input  logic [data_width-1:0] r_data,
  input  logic                  empty,
  input  logic                  full,
  output logic                  res_valid,
  output logic [data_width-1:0] res_data,
  output logic                  err,
  output logic [addr_width:0]   depth
);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;

  localparam logic [addr_width:0] CAP = {1'b1, {addr_width{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, POP_A, POP_B, PUSH_R, DO_PUSH, DO_DROP, DO_PEEK, ERR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_op;
  logic [data_width-1:0] r_operand;
  logic [data_width-1:0] r_a;
  logic [data_width-1:0] r_b;
  logic [addr_width:0]   r_depth;
  logic [data_width-1:0] w_result;
  logic                  w_room;
  logic                  w_has1;
  logic                  w_has2;

  assign w_room = (r_depth < CAP) && !full;
  assign w_has1 = (r_depth != '0) && !empty;
  assign w_has2 = r_depth >= (addr_width+1)'(2);
  assign depth  = r_depth;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_operand <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_depth   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && cmd_valid) begin
        r_op      <= cmd_op;
        r_operand <= cmd_operand;
      end
      // DUP reuses the peek read cycle to capture the top into a
      if (r_state == POP_A || (r_state == DO_PEEK && r_op == OP_DUP))
        r_a <= r_data;
      if (r_state == POP_B)
        r_b <= r_data;
      if (push)
        r_depth <= r_depth + 1'b1;
      else if (pop)
        r_depth <= r_depth - 1'b1;
    end
  end

  always_comb begin
    w_result = r_a;
    case (r_op)
      OP_ADD:  w_result = r_b + r_a;
      OP_SUB:  w_result = r_b - r_a;
      OP_AND:  w_result = r_b & r_a;
      OP_XOR:  w_result = r_b ^ r_a;
      default: w_result = r_a;
    endcase
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH:                        w_next = w_room ? DO_PUSH : ERR;
            OP_ADD, OP_SUB, OP_AND, OP_XOR: w_next = w_has2 ? POP_A : ERR;
            OP_DUP:                         w_next = (w_has1 && w_room) ? DO_PEEK : ERR;
            OP_DROP:                        w_next = w_has1 ? DO_DROP : ERR;
            default:                        w_next = w_has1 ? DO_PEEK : ERR;
          endcase
        end
      end
      POP_A:   w_next = POP_B;
      POP_B:   w_next = PUSH_R;
      DO_PEEK: w_next = (r_op == OP_DUP) ? PUSH_R : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    w_data    = '0;
    res_valid = 1'b0;
    res_data  = '0;
    err       = 1'b0;
    case (r_state)
      IDLE:    cmd_ready = 1'b1;
      POP_A,
      POP_B:   pop = 1'b1;
      DO_PUSH: begin
        push      = 1'b1;
        w_data    = r_operand;
        res_valid = 1'b1;
        res_data  = r_operand;
      end
      PUSH_R: begin
        push      = 1'b1;
        w_data    = w_result;
        res_valid = 1'b1;
        res_data  = w_result;
      end
      DO_DROP: begin
        pop       = 1'b1;
        res_valid = 1'b1;
        res_data  = r_data;
      end
      DO_PEEK: begin
        if (r_op != OP_DUP) begin
          res_valid = 1'b1;
          res_data  = r_data;
        end
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

endmodule
